// File: rtl/nor_pkg.sv
// Shared types and helpers for the NOR flash read controller.
// Covers bus modes, controller states, command opcodes and lane-count helpers.
package nor_pkg;

    typedef enum logic [1:0] {
        MODE_SPI  = 2'd0,
        MODE_DPI  = 2'd1,
        MODE_QPI  = 2'd2,
        MODE_RSVD = 2'd3
    } nor_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } nor_state_e;

    localparam logic [7:0] CMD_SPI = 8'h03;
    localparam logic [7:0] CMD_DPI = 8'hBB;
    localparam logic [7:0] CMD_QPI = 8'hEB;

    function automatic logic [2:0] lane_count(input nor_mode_e m);
        case (m)
            MODE_DPI: return 3'd2;
            MODE_QPI: return 3'd4;
            default:  return 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] cmd_code(input nor_mode_e m);
        case (m)
            MODE_DPI: return CMD_DPI;
            MODE_QPI: return CMD_QPI;
            default:  return CMD_SPI;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] lanes);
        case (lanes)
            3'd4:    return 4'b1111;
            3'd2:    return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    // Lane counts are powers of two, so the sck-cycle count is a plain shift.
    function automatic logic [7:0] phase_len(input logic [7:0] bits, input logic [2:0] lanes);
        case (lanes)
            3'd4:    return bits >> 2;
            3'd2:    return bits >> 1;
            default: return bits;
        endcase
    endfunction

endpackage

// File: rtl/nor_sck_gen.sv
// Flash clock divider: sck high then low for SCK_HALF clk cycles each.
// Rise/fall strobes flag the clk edge that is about to move sck.
module nor_sck_gen
    import nor_pkg::*;
#(
    parameter int unsigned SCK_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] LAST = 4'(SCK_HALF - 1);

    logic [3:0] cnt;

    // Parking the counter at LAST makes the first enabled edge raise sck.
    assign tick = (cnt == LAST);
    assign rise = en && tick && !sck;
    assign fall = en && tick && sck;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= LAST;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/nor_read_ctrl.sv
// NOR flash read controller: issues command/address/dummy phases in SPI, DPI
// or QPI and returns up to four little-endian data bytes with a ready pulse.
module nor_read_ctrl
    import nor_pkg::*;
#(
    parameter int unsigned SCK_HALF  = 1,
    parameter int unsigned CS_HIGH   = 4,
    parameter int unsigned DPI_DUMMY = 8,
    parameter int unsigned QPI_DUMMY = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        req,
    input  logic [23:0] addr,
    input  logic [1:0]  size,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        sck,
    output logic        csb,
    output logic [3:0]  sio_out,
    output logic [3:0]  sio_oe,
    input  logic [3:0]  sio_in
);

    localparam logic [15:0] GAP_LAST = 16'((CS_HIGH > 0) ? CS_HIGH - 1 : 0);

    nor_state_e state, state_nx;
    nor_mode_e  mode_q;
    nor_mode_e  mode_in;
    logic [1:0]  size_q;
    logic [2:0]  lanes_q;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [7:0]  remain;
    logic [7:0]  next_len;
    logic [7:0]  dummy_len;
    logic [7:0]  data_bits;
    logic [15:0] gap_cnt;
    logic [31:0] rdata_nx;
    logic        busy;
    logic        finish;
    logic        phase_done;
    logic        sck_en;
    logic        tick;
    logic        rise;
    logic        fall;

    assign mode_in   = nor_mode_e'(mode);
    assign lanes_q   = lane_count(mode_q);
    assign busy      = (state == ST_CMD) || (state == ST_ADDR) ||
                       (state == ST_DUMMY) || (state == ST_DATA);
    assign sck_en    = busy && !finish;
    assign csb       = !busy;
    assign dummy_len = (lanes_q == 3'd2) ? 8'(DPI_DUMMY) : 8'(QPI_DUMMY);

    always_comb begin
        case (size_q)
            2'd0:    data_bits = 8'd8;
            2'd1:    data_bits = 8'd16;
            default: data_bits = 8'd32;
        endcase
    end

    nor_sck_gen #(
        .SCK_HALF(SCK_HALF)
    ) u_sck_gen (
        .clk (clk),
        .rst (rst),
        .en  (sck_en),
        .sck (sck),
        .tick(tick),
        .rise(rise),
        .fall(fall)
    );

    // Phases advance on the falling edge that closes their last sck cycle;
    // the transaction ends where the next rise would have been.
    always_comb begin
        state_nx   = state;
        finish     = 1'b0;
        phase_done = fall && (remain == 8'd1);
        case (state)
            ST_IDLE:  if (req) state_nx = ST_CMD;
            ST_CMD:   if (phase_done) state_nx = ST_ADDR;
            ST_ADDR: begin
                if (phase_done)
                    state_nx = (lanes_q == 3'd1 || dummy_len == 8'd0) ? ST_DATA : ST_DUMMY;
            end
            ST_DUMMY: if (phase_done) state_nx = ST_DATA;
            ST_DATA: begin
                if (remain == 8'd0 && tick && !sck) begin
                    finish   = 1'b1;
                    state_nx = ST_GAP;
                end
            end
            ST_GAP:   if (gap_cnt == 16'd0) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state_nx)
            ST_ADDR:  next_len = phase_len(8'd24, lanes_q);
            ST_DUMMY: next_len = dummy_len;
            ST_DATA:  next_len = phase_len(data_bits, lanes_q);
            default:  next_len = 8'd0;
        endcase
    end

    // Bytes arrive MSB-first in stream order; the first one belongs in rdata[7:0].
    always_comb begin
        case (size_q)
            2'd0:    rdata_nx = {24'h0, rx[7:0]};
            2'd1:    rdata_nx = {16'h0, rx[7:0], rx[15:8]};
            default: rdata_nx = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    end

    always_comb begin
        sio_out = '0;
        sio_oe  = '0;
        if (state == ST_CMD || state == ST_ADDR) begin
            sio_oe = lane_mask(lanes_q);
            case (lanes_q)
                3'd4:    sio_out = tx[31:28];
                3'd2:    sio_out = {2'b00, tx[31:30]};
                default: sio_out = {3'b000, tx[31]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_SPI;
            size_q  <= '0;
            tx      <= '0;
            rx      <= '0;
            remain  <= '0;
            gap_cnt <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_nx;
            ready <= finish;

            if (state == ST_IDLE && req) begin
                mode_q <= mode_in;
                size_q <= size;
                tx     <= {cmd_code(mode_in), addr};
                rx     <= '0;
                remain <= phase_len(8'd8, lane_count(mode_in));
            end

            if (fall) begin
                if (state == ST_CMD || state == ST_ADDR)
                    tx <= tx << lanes_q;
                remain <= (phase_done && state != ST_DATA) ? next_len : remain - 8'd1;
            end

            // SPI read data comes back on IO1, the flash's DO pin.
            if (rise && state == ST_DATA) begin
                case (lanes_q)
                    3'd4:    rx <= {rx[27:0], sio_in};
                    3'd2:    rx <= {rx[29:0], sio_in[1:0]};
                    default: rx <= {rx[30:0], sio_in[1]};
                endcase
            end

            if (finish) begin
                rdata   <= rdata_nx;
                gap_cnt <= GAP_LAST;
            end else if (state == ST_GAP && gap_cnt != 16'd0) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nor_read_ctrl.sv
// Scoreboard bench for nor_read_ctrl with a behavioural flash and reference model.
module tb_nor_read_ctrl;

    localparam int unsigned SCK_HALF  = 1;
    localparam int unsigned CS_HIGH   = 4;
    localparam int unsigned DPI_DUMMY = 8;
    localparam int unsigned QPI_DUMMY = 10;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        req;
    logic [23:0] addr;
    logic [1:0]  size;
    logic        ready;
    logic [31:0] rdata;
    logic        sck;
    logic        csb;
    logic [3:0]  sio_out;
    logic [3:0]  sio_oe;
    logic [3:0]  sio_in;

    nor_read_ctrl #(
        .SCK_HALF (SCK_HALF),
        .CS_HIGH  (CS_HIGH),
        .DPI_DUMMY(DPI_DUMMY),
        .QPI_DUMMY(QPI_DUMMY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .req    (req),
        .addr   (addr),
        .size   (size),
        .ready  (ready),
        .rdata  (rdata),
        .sck    (sck),
        .csb    (csb),
        .sio_out(sio_out),
        .sio_oe (sio_oe),
        .sio_in (sio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned nsck;
        logic [7:0]  cmd;
        logic [23:0] addr;
        int unsigned acc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] want;
    } imm_t;

    exp_t        exp_q[$];
    imm_t        imm_q[$];
    logic [7:0]  mem[256];
    logic [1:0]  cur_mode;
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned ready_cnt = 0;
    int unsigned idle_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned lanes_of(input logic [1:0] m);
        return (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
    endfunction

    function automatic int unsigned dummy_of(input int unsigned l);
        return (l == 1) ? 0 : (l == 2) ? DPI_DUMMY : QPI_DUMMY;
    endfunction

    // Reference model: what a correct read of this request must return and how long it takes.
    function automatic exp_t model(input logic [1:0] m, input logic [23:0] a,
                                   input logic [1:0] s, input int unsigned acc);
        exp_t e;
        int unsigned l, nb;
        logic [23:0] ai;
        l  = lanes_of(m);
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        e.rdata = '0;
        for (int unsigned i = 0; i < nb; i++) begin
            ai = a + 24'(i);
            e.rdata = e.rdata | (32'(mem[ai[7:0]]) << (8 * i));
        end
        e.nsck = 8 / l + 24 / l + dummy_of(l) + 8 * nb / l;
        e.lat  = 1 + 2 * SCK_HALF * e.nsck;
        e.cmd  = (l == 1) ? 8'h03 : (l == 2) ? 8'hBB : 8'hEB;
        e.addr = a;
        e.acc  = acc;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask

    task automatic post(input string nm, input logic [31:0] got, input logic [31:0] want);
        imm_t t;
        t.name = nm;
        t.got  = got;
        t.want = want;
        imm_q.push_back(t);
    endtask

    // Flash model, bus-rule observers and scoreboard monitor share one process.
    int unsigned f_cyc = 0, f_l = 1, f_oebad = 0, hi_run = 0;
    logic [31:0] f_sh = '0;
    logic        sck_d = 1'b0, csb_d = 1'b1, seen_txn = 1'b0;

    always @(negedge clk) begin
        logic [3:0]  msk, sin;
        logic [7:0]  byt;
        logic [23:0] ba;
        int unsigned dstart, bp;
        exp_t e;
        imm_t t;

        if (rst) sio_in = '0;
        if (!csb && csb_d) begin
            f_cyc = 0; f_sh = '0; f_oebad = 0; f_l = lanes_of(cur_mode);
        end
        msk = (f_l == 1) ? 4'b0001 : (f_l == 2) ? 4'b0011 : 4'b1111;
        if (sck && !sck_d) begin
            if (f_cyc < 32 / f_l) begin
                if (sio_oe != msk) f_oebad++;
                f_sh = (f_sh << f_l) | 32'(sio_out & msk);
            end else if (sio_oe != 4'b0000) begin
                f_oebad++;
            end
            f_cyc++;
        end
        if (!sck && sck_d && !csb) begin
            dstart = 32 / f_l + dummy_of(f_l);
            if (f_cyc >= dstart) begin
                bp  = (f_cyc - dstart) * f_l;
                ba  = f_sh[23:0] + 24'(bp / 8);
                byt = mem[ba[7:0]] >> (8 - (bp % 8) - f_l);
                sin = 4'($urandom);
                if (f_l == 1) sin[1] = byt[0];
                else if (f_l == 2) sin[1:0] = byt[1:0];
                else sin = byt[3:0];
                sio_in = sin;
            end
        end
        if (csb && sck) idle_bad++;

        if (rst) begin
            hi_run = 0;
        end else if (csb) begin
            hi_run++;
        end else begin
            if (csb_d && seen_txn) begin
                n_total++;
                if (hi_run >= CS_HIGH) n_pass++;
                else $display("FAIL csb_high_gap: got %0d cycles need >= %0d", hi_run, CS_HIGH);
            end
            hi_run   = 0;
            seen_txn = 1'b1;
        end

        if (!rst && ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending request");
            end else begin
                e = exp_q.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("cmd_byte", {24'h0, f_sh[31:24]}, {24'h0, e.cmd});
                chk("addr_sent", {8'h0, f_sh[23:0]}, {8'h0, e.addr});
                chk("sck_cycles", 32'(f_cyc), 32'(e.nsck));
                chk("sio_oe_phase_errs", 32'(f_oebad), 32'd0);
            end
        end

        while (imm_q.size() > 0) begin
            t = imm_q.pop_front();
            chk(t.name, t.got, t.want);
        end
        sck_d = sck;
        csb_d = csb;
    end

    task automatic start_req(input logic [1:0] m, input logic [23:0] a,
                             input logic [1:0] s, output bit ok);
        cur_mode = m;
        mode = m; addr = a; size = s; req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!csb) begin ok = 1'b1; break; end
        end
        if (!ok) post("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_read(input logic [1:0] m, input logic [23:0] a, input logic [1:0] s,
                           input int drop_at, input int flip_at, input logic [1:0] flip_to);
        bit ok, got;
        start_req(m, a, s, ok);
        if (!ok) begin req = 1'b0; return; end
        exp_q.push_back(model(m, a, s, cyc));
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == drop_at) req = 1'b0;
            if (i == flip_at) mode = flip_to;
            if (ready) begin got = 1'b1; break; end
        end
        req = 1'b0;
        if (!got) post("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        int unsigned saved;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        cur_mode = 2'd0;
        rst = 1'b1; req = 1'b0; mode = 2'd0; addr = '0; size = '0;
        repeat (3) @(negedge clk);
        post("rst_csb", {31'h0, csb}, 32'd1);
        post("rst_sck", {31'h0, sck}, 32'd0);
        post("rst_sio_oe", {28'h0, sio_oe}, 32'd0);
        post("rst_sio_out", {28'h0, sio_out}, 32'd0);
        post("rst_ready", {31'h0, ready}, 32'd0);
        post("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_read(2'd0, 24'h000010, 2'd2, -1, -1, 2'd0);
        post("spi_4byte_value", rdata, 32'h44332211);
        do_read(2'd1, 24'h000010, 2'd0, -1, -1, 2'd0);
        post("dpi_1byte_value", rdata, 32'h00000011);
        do_read(2'd2, 24'h000012, 2'd1, -1, -1, 2'd0);
        post("qpi_2byte_value", rdata, 32'h00004433);

        do_read(2'd0, 24'h000011, 2'd1, -1, -1, 2'd0);
        do_read(2'd0, 24'h000012, 2'd2, -1, -1, 2'd0);

        start_req(2'd0, 24'h0000A5, 2'd2, ok);
        repeat (2 * SCK_HALF * 8 + 8) @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        post("abort_csb", {31'h0, csb}, 32'd1);
        post("abort_sck", {31'h0, sck}, 32'd0);
        post("abort_sio_oe", {28'h0, sio_oe}, 32'd0);
        post("abort_ready", {31'h0, ready}, 32'd0);
        rst = 1'b0;
        saved = ready_cnt;
        repeat (150) @(negedge clk);
        post("abort_no_ready", ready_cnt, saved);
        do_read(2'd0, 24'h000010, 2'd2, -1, -1, 2'd0);

        do_read(2'd0, 24'h000013, 2'd2, 5, 12, 2'd2);
        do_read(2'd2, 24'hFFFFFF, 2'd3, -1, -1, 2'd0);
        do_read(2'd3, 24'hFFFFFE, 2'd1, -1, -1, 2'd0);
        do_read(2'd1, 24'hFFFFFF, 2'd2, 3, -1, 2'd0);

        for (int n = 0; n < 24; n++) begin
            logic [1:0]  m, s;
            logic [23:0] a;
            int          d, f;
            m = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
            d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : -1;
            f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : -1;
            do_read(m, a, s, d, f, 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        post("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        post("sck_while_deselected", idle_bad, 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
